// File: rtl/join_lane_fifo.sv
// One lane of the join: a circular FIFO of DEPTH entries with occupancy count.
// Storage is not reset; only pointers and count are.
module join_lane_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic                      pop,
  input  logic [DATA_WIDTH-1:0]     in_data,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // DEPTH is a power of two, so pointer wrap is the natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  assign out_data = mem_q[rd_ptr_q];
  assign count    = count_q;

endmodule

// File: rtl/join_n_buffered.sv
// Joins N independently buffered streams into one wide beat; all lanes pop together.
// Ready and valid depend only on registered state, never on the opposite handshake.
module join_n_buffered #(
  parameter int N          = 10,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N*DATA_WIDTH-1:0]   data_in,
  input  logic [N-1:0]              data_in_valid,
  output logic [N-1:0]              data_in_ready,
  output logic [N*DATA_WIDTH-1:0]   data_out,
  output logic                      data_out_valid,
  input  logic                      data_out_ready
);

  localparam int               CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

  logic [CNT_W-1:0] lane_count [N];
  logic [N-1:0]     lane_nonempty;
  logic [N-1:0]     lane_push;
  logic             pop;
  logic             ready_en_q, ready_en_d;

  // Holds ready low while in reset and rises on the first edge after release.
  always_comb ready_en_d = 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ready_en_q <= 1'b0;
    else      ready_en_q <= ready_en_d;
  end

  assign data_out_valid = &lane_nonempty;
  assign pop            = data_out_valid & data_out_ready;

  for (genvar i = 0; i < N; i++) begin : g_lane
    assign data_in_ready[i] = ready_en_q && (lane_count[i] != FULL);
    assign lane_nonempty[i] = (lane_count[i] != '0);
    assign lane_push[i]     = data_in_valid[i] & data_in_ready[i];

    join_lane_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
    ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (lane_push[i]),
      .pop      (pop),
      .in_data  (data_in[i*DATA_WIDTH +: DATA_WIDTH]),
      .out_data (data_out[i*DATA_WIDTH +: DATA_WIDTH]),
      .count    (lane_count[i])
    );
  end

endmodule

// File: tb/tb_join_n_buffered.sv
// Bench for join_n_buffered with N=3, DATA_WIDTH=8, DEPTH=2: per-lane scoreboard
// queues filled on accepted pushes and drained on accepted joined beats.
module tb_join_n_buffered;

  logic        clk;
  logic        rst;
  logic [23:0] data_in;
  logic [2:0]  data_in_valid;
  logic [2:0]  data_in_ready;
  logic [23:0] data_out;
  logic        data_out_valid;
  logic        data_out_ready;

  join_n_buffered #(.N(3), .DATA_WIDTH(8), .DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .data_in        (data_in),
    .data_in_valid  (data_in_valid),
    .data_in_ready  (data_in_ready),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef logic [7:0] byte_q_t [$];
  byte_q_t mq [3];
  int      beat_cyc [$];
  int      checks = 0;
  int      errors = 0;
  int      cyc = 0;
  logic    en_m = 1'b0;

  // One clock: compare at negedge against the model, then update it at posedge.
  task automatic advance();
    logic [2:0]  exp_rdy;
    logic        exp_vld;
    logic [23:0] exp_data;
    logic [2:0]  push;
    logic        pop;
    @(negedge clk);
    exp_vld = (mq[0].size() > 0) && (mq[1].size() > 0) && (mq[2].size() > 0);
    for (int i = 0; i < 3; i++) exp_rdy[i] = en_m && (mq[i].size() < 2);
    checks++;
    if (data_out_valid !== exp_vld) begin
      errors++;
      $display("FAIL sb_valid cyc=%0d got=%b exp=%b", cyc, data_out_valid, exp_vld);
    end
    checks++;
    if (data_in_ready !== exp_rdy) begin
      errors++;
      $display("FAIL sb_ready cyc=%0d got=%b exp=%b", cyc, data_in_ready, exp_rdy);
    end
    if (exp_vld) begin
      exp_data = {mq[2][0], mq[1][0], mq[0][0]};
      checks++;
      if (data_out !== exp_data) begin
        errors++;
        $display("FAIL sb_data cyc=%0d got=%h exp=%h", cyc, data_out, exp_data);
      end
    end
    pop  = exp_vld && data_out_ready;
    push = data_in_valid & exp_rdy;
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < 3; i++) mq[i].delete();
      en_m = 1'b0;
    end else begin
      if (pop) begin
        for (int i = 0; i < 3; i++) mq[i].delete(0);
        beat_cyc.push_back(cyc);
      end
      for (int i = 0; i < 3; i++) if (push[i]) mq[i].push_back(data_in[i*8 +: 8]);
      en_m = 1'b1;
    end
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    data_in_valid = 3'b111;
    data_in = 24'hAABBCC;
    data_out_ready = 1'b1;
    repeat (3) begin
      advance();
      checks++;
      if (data_in_ready !== 3'b000 || data_out_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold ready=%b valid=%b exp ready=000 valid=0", data_in_ready, data_out_valid);
      end
    end
    rst = 1'b1;
    data_in_valid = 3'b000;
    advance();
    checks++;
    if (data_in_ready !== 3'b111) begin
      errors++;
      $display("FAIL reset_release_ready got=%b exp=111", data_in_ready);
    end
    repeat (2) begin
      advance();
      checks++;
      if (data_out_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_no_beat got=%b exp=0", data_out_valid);
      end
    end
  endtask

  task automatic test_skewed();
    data_out_ready = 1'b1;
    data_in = 24'h332211;
    for (int c = 0; c < 8; c++) begin
      data_in_valid = (c == 0) ? 3'b001 : (c == 2) ? 3'b010 : (c == 4) ? 3'b100 : 3'b000;
      advance();
      if (c < 4) begin
        checks++;
        if (data_out_valid !== 1'b0) begin
          errors++;
          $display("FAIL skew_early c=%0d valid=%b exp=0", c, data_out_valid);
        end
      end else if (c == 4) begin
        checks++;
        if (data_out_valid !== 1'b1 || data_out !== 24'h332211) begin
          errors++;
          $display("FAIL skew_beat valid=%b data=%h exp valid=1 data=332211", data_out_valid, data_out);
        end
      end else if (c == 5) begin
        checks++;
        if (data_out_valid !== 1'b0) begin
          errors++;
          $display("FAIL skew_after valid=%b exp=0", data_out_valid);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int base;
    base = beat_cyc.size();
    data_out_ready = 1'b0;
    data_in_valid = 3'b111;
    data_in = 24'hC0B0A0;
    advance();
    data_in_valid = 3'b001;
    data_in = 24'h0000A1;
    advance();
    checks++;
    if (data_in_ready !== 3'b110) begin
      errors++;
      $display("FAIL bp_full_ready got=%b exp=110", data_in_ready);
    end
    data_in = 24'h0000A2;
    repeat (3) begin
      advance();
      checks++;
      if (data_out_valid !== 1'b1 || data_out !== 24'hC0B0A0 || data_in_ready[0] !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold valid=%b data=%h rdy0=%b exp valid=1 data=c0b0a0 rdy0=0",
                 data_out_valid, data_out, data_in_ready[0]);
      end
    end
    data_out_ready = 1'b1;
    advance();
    checks++;
    if (data_in_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL bp_ready_return got=%b exp=1", data_in_ready[0]);
    end
    advance();
    data_in_valid = 3'b110;
    data_in = 24'hC1B100;
    advance();
    data_in = 24'hC2B200;
    advance();
    data_in_valid = 3'b000;
    repeat (2) advance();
    checks++;
    if (beat_cyc.size() - base !== 3) begin
      errors++;
      $display("FAIL bp_beats got=%0d exp=3", beat_cyc.size() - base);
    end
  endtask

  task automatic test_streaming();
    int base;
    logic [3:0] k4;
    base = beat_cyc.size();
    data_out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      k4 = 4'(k);
      data_in = {4'h2, k4, 4'h1, k4, 4'h0, k4};
      data_in_valid = 3'b111;
      advance();
      if (k == 0) begin
        checks++;
        if (data_out_valid !== 1'b1 || data_out !== 24'h201000) begin
          errors++;
          $display("FAIL stream_first valid=%b data=%h exp valid=1 data=201000", data_out_valid, data_out);
        end
      end
    end
    data_in_valid = 3'b000;
    repeat (2) advance();
    checks++;
    if (beat_cyc.size() - base !== 10) begin
      errors++;
      $display("FAIL stream_beats got=%0d exp=10", beat_cyc.size() - base);
    end else begin
      checks++;
      if (beat_cyc[base + 9] - beat_cyc[base] !== 9) begin
        errors++;
        $display("FAIL stream_bubbles span=%0d exp=9", beat_cyc[base + 9] - beat_cyc[base]);
      end
    end
  endtask

  task automatic test_midreset();
    data_out_ready = 1'b0;
    data_in_valid = 3'b111;
    data_in = 24'h6BD05A;
    advance();
    data_in_valid = 3'b010;
    data_in = 24'h00D100;
    advance();
    data_in_valid = 3'b000;
    checks++;
    if (data_out_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre valid=%b exp=1", data_out_valid);
    end
    #2;
    rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) mq[i].delete();
    en_m = 1'b0;
    checks++;
    if (data_out_valid !== 1'b0 || data_in_ready !== 3'b000) begin
      errors++;
      $display("FAIL mid_async valid=%b ready=%b exp valid=0 ready=000", data_out_valid, data_in_ready);
    end
    advance();
    rst = 1'b1;
    repeat (2) advance();
    checks++;
    if (data_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_stale valid=%b exp=0", data_out_valid);
    end
    data_out_ready = 1'b1;
    data_in_valid = 3'b111;
    data_in = 24'h737271;
    advance();
    data_in_valid = 3'b000;
    checks++;
    if (data_out_valid !== 1'b1 || data_out !== 24'h737271) begin
      errors++;
      $display("FAIL mid_new valid=%b data=%h exp valid=1 data=737271", data_out_valid, data_out);
    end
    repeat (2) advance();
  endtask

  initial begin
    rst = 1'b1;
    data_in = '0;
    data_in_valid = '0;
    data_out_ready = 1'b0;
    #1;
    test_reset();
    test_skewed();
    test_backpressure();
    test_streaming();
    test_midreset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/join_n_buffered.md
JOIN_N_BUFFERED -- requirements
Module: join_n_buffered

Interface
REQ-001 SHALL have parameter N, default 10, number of joined input streams (N >= 1).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, payload width per lane.
REQ-003 SHALL have parameter DEPTH, default 2, per-lane buffer entries (power of two, >= 2).
REQ-004 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port rst  in  1  reset; asynchronous, active-low.
REQ-006 SHALL have port data_in  in  N x DATA_WIDTH  lane i payload.
REQ-007 SHALL have port data_in_valid  in  N  lane i valid.
REQ-008 SHALL have port data_in_ready  out  N  lane i ready.
REQ-009 SHALL have port data_out  out  N x DATA_WIDTH  joined payload; lane i at index i.
REQ-010 SHALL have port data_out_valid  out  1  joined beat available.
REQ-011 SHALL have port data_out_ready  in  1  consumer accepts joined beat.

Function
REQ-012 Each lane SHALL own an independent circular FIFO of DEPTH entries: write pointer, read pointer, and occupancy count of width clog2(DEPTH)+1.
REQ-013 Lane i push SHALL occur when data_in_valid[i] && data_in_ready[i]; the lane's write pointer advances mod DEPTH.
REQ-014 data_in_ready[i] SHALL be 1 iff lane i count < DEPTH; it is a function of registered state only, with no combinational path from data_out_ready or any data_in_valid.
REQ-015 data_out_valid SHALL be 1 iff every lane count >= 1; it is a function of registered state only.
REQ-016 Pop SHALL occur when data_out_valid && data_out_ready; all N lanes pop in the same cycle and read pointers advance mod DEPTH.
REQ-017 data_out[i] SHALL equal the entry at lane i's read pointer, holding stable while data_out_valid && !data_out_ready.
REQ-018 Latency SHALL be 1 cycle: a push at edge k makes the word visible at data_out after edge k when all other lanes are non-empty.
REQ-019 Push and pop in the same cycle on one lane SHALL leave that lane's count unchanged and update both pointers.
REQ-020 A full lane SHALL NOT accept a push even if a pop occurs in that cycle, so ready never depends on data_out_ready.
REQ-021 Pointer wrap from DEPTH-1 to 0 SHALL preserve FIFO ordering with no lost or duplicated word.
REQ-022 Throughput SHALL be one joined beat per cycle when all lanes stream continuously and data_out_ready stays high, given DEPTH >= 2.
REQ-023 The data_out_valid and data_out_ready handshake SHALL follow the valid/ready rule: once valid is asserted, it stays asserted with stable data until accepted.
REQ-024 For N == 1 the block SHALL behave as a single DEPTH-entry FIFO.

Reset
REQ-025 While rst = 0, all counts and pointers SHALL be 0, data_out_valid 0, and data_in_ready all 0.
REQ-026 On the first edge after rst deasserts, data_in_ready SHALL be all 1. FIFO storage contents need no reset.
REQ-027 Reset asserted mid-operation SHALL discard all buffered words immediately, with no pop or push completing in that cycle.

Structure
REQ-028 No shared package SHALL be required; widths derive locally from parameters via clog2.
REQ-029 The per-lane FIFO SHALL be a sub-module, join_lane_fifo (ports clk, rst, push, pop, in_data, out_data, count), instantiated N times in a generate loop.
REQ-030 The top level SHALL contain only the lane-count AND reduction for data_out_valid and the pop broadcast.

Verification
REQ-031 Verification SHALL use N=3, DATA_WIDTH=8, DEPTH=2 for all scenarios below.
REQ-032 Reset: hold rst=0 for 3 cycles with all inputs valid -> data_in_ready=000 and data_out_valid=0; after release, ready=111 and no beat appears until pushes occur.
REQ-033 Skewed arrival: lane0 pushes 0x11 at cycle 1, lane1 pushes 0x22 at cycle 3, lane2 pushes 0x33 at cycle 5, with data_out_ready=1 -> data_out_valid is first 1 at cycle 6 with data_out={0x33,0x22,0x11}, then 0.
REQ-034 Backpressure: data_out_ready=0 and lane0 pushes 0xA0, 0xA1, 0xA2 -> data_in_ready[0] drops to 0 after the second push; 0xA2 is held off; the output shows 0xA0 stable until ready is raised.
REQ-035 Streaming and wrap: all lanes push lane-tagged counters 0..9 every cycle with data_out_ready=1 -> 10 consecutive beats in order, one per cycle, pointers wrap 5 times, and no bubbles after the first beat.
REQ-036 Mid-operation reset: pulse rst=0 while lane1 holds 2 words -> data_out_valid falls asynchronously; after release, old words never appear at the output.
